// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
// The package defaults match the sequencer's default parameters.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    DLY,
    WAIT_RDY,
    RUN,
    SHUTDOWN,
    SWHOLD,
    FAULT
  } seq_state_e;

  localparam int N_DOM_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 3;
  localparam int REL_DLY_DEF     = 16;
  localparam int ACK_TMO_DEF     = 256;

  // The counter is shared by the release delay and the ready timeout.
  function automatic int cnt_width(input int rel_dly, input int ack_tmo);
    int m;
    m = (rel_dly > ack_tmo) ? rel_dly : ack_tmo;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_width(input int n_dom);
    return (n_dom < 2) ? 1 : $clog2(n_dom);
  endfunction

  localparam int CNT_W = cnt_width(REL_DLY_DEF, ACK_TMO_DEF);
  localparam int IDX_W = idx_width(N_DOM_DEF);

endpackage

// File: rtl/rst_seq_if.sv
// Bundle of software-request, domain handshake and status signals around
// the reset sequencer; master is the sequencer side.
interface rst_seq_if
  import rst_seq_pkg::*;
#(
  parameter int N_DOM = N_DOM_DEF
);

  localparam int IW = idx_width(N_DOM);

  logic             i_sw_rst;
  logic [N_DOM-1:0] i_dom_ready;
  logic [N_DOM-1:0] o_dom_rst_n;
  logic             o_all_ready;
  logic             o_busy;
  logic             o_tmo_err;
  logic [IW-1:0]    o_tmo_idx;

  modport master (
    input  i_sw_rst,
    input  i_dom_ready,
    output o_dom_rst_n,
    output o_all_ready,
    output o_busy,
    output o_tmo_err,
    output o_tmo_idx
  );

  modport slave (
    output i_sw_rst,
    output i_dom_ready,
    input  o_dom_rst_n,
    input  o_all_ready,
    input  o_busy,
    input  o_tmo_err,
    input  o_tmo_idx
  );

endinterface

// File: rtl/rst_seq_sync.sv
// Board reset synchroniser: asserts asynchronously, deasserts on the
// SYNC_STAGES-th rising clock edge after i_arst_n goes high.
module rst_seq_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic i_clk,
  input  logic i_arst_n,
  output logic srst_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign srst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset tree sequencer: ordered domain release with ready handshakes,
// software-requested descending shutdown and timeout reporting.
// Optional RUN-state ready monitor: define RST_SEQ_READY_MON_EN.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_DOM       = N_DOM_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int REL_DLY     = REL_DLY_DEF,
  parameter int ACK_TMO     = ACK_TMO_DEF
) (
  input  logic      i_clk,
  input  logic      i_arst_n,
  rst_seq_if.master sif
);

  localparam int CW = cnt_width(REL_DLY, ACK_TMO);
  localparam int IW = idx_width(N_DOM);

  if (N_DOM < 2 || N_DOM > 16) begin : g_bad_n_dom
    $error("rst_sequencer: N_DOM must be within 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_sequencer: SYNC_STAGES must be at least 2");
  end
  if (REL_DLY < 1 || ACK_TMO < 2) begin : g_bad_dly
    $error("rst_sequencer: REL_DLY >= 1 and ACK_TMO >= 2 required");
  end

  logic srst_n;

  rst_seq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .srst_n  (srst_n)
  );

  seq_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
  logic             tmo_err_q, tmo_err_d;
  logic [IW-1:0]    tmo_idx_q, tmo_idx_d;
  logic             sw_rst_p0, sw_rst_p1;
  logic             sw_evt;

  // Stage p0 registers the request, p1 delays it for edge detection.
  always_ff @(posedge i_clk or negedge srst_n) begin
    if (!srst_n) begin
      sw_rst_p0 <= 1'b0;
      sw_rst_p1 <= 1'b0;
    end else begin
      sw_rst_p0 <= sif.i_sw_rst;
      sw_rst_p1 <= sw_rst_p0;
    end
  end

  assign sw_evt = sw_rst_p0 & ~sw_rst_p1;

`ifdef RST_SEQ_READY_MON_EN
  logic [N_DOM-1:0] rdy_low_p0;
  logic [N_DOM-1:0] rdy_low2;

  function automatic logic [IW-1:0] lowest_idx(input logic [N_DOM-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Only low samples taken while in RUN count towards a fault.
  always_ff @(posedge i_clk or negedge srst_n) begin
    if (!srst_n) begin
      rdy_low_p0 <= '0;
    end else begin
      rdy_low_p0 <= (state_q == RUN) ? ~sif.i_dom_ready : '0;
    end
  end

  assign rdy_low2 = rdy_low_p0 & ~sif.i_dom_ready;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dom_rst_n_d = dom_rst_n_q;
    tmo_err_d   = tmo_err_q;
    tmo_idx_d   = tmo_idx_q;

    case (state_q)
      HOLD: begin
        dom_rst_n_d = '0;
        state_d     = DLY;
        idx_d       = '0;
        cnt_d       = '0;
      end

      DLY: begin
        if (sw_evt) begin
          // Domains below idx are the ones already released.
          if (idx_q == '0) begin
            state_d = SWHOLD;
          end else begin
            state_d = SHUTDOWN;
            idx_d   = idx_q - 1'b1;
          end
        end else if (cnt_q == CW'(REL_DLY - 1)) begin
          dom_rst_n_d[idx_q] = 1'b1;
          cnt_d              = '0;
          state_d            = WAIT_RDY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_RDY: begin
        if (sw_evt) begin
          state_d = SHUTDOWN;
        end else if (sif.i_dom_ready[idx_q]) begin
          if (idx_q == IW'(N_DOM - 1)) begin
            state_d = RUN;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            state_d = DLY;
          end
        end else if (cnt_q == CW'(ACK_TMO - 1)) begin
          state_d     = FAULT;
          tmo_err_d   = 1'b1;
          tmo_idx_d   = idx_q;
          dom_rst_n_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (sw_evt) begin
          state_d = SHUTDOWN;
          idx_d   = IW'(N_DOM - 1);
        end
`ifdef RST_SEQ_READY_MON_EN
        else if (|rdy_low2) begin
          state_d     = FAULT;
          tmo_err_d   = 1'b1;
          tmo_idx_d   = lowest_idx(rdy_low2);
          dom_rst_n_d = '0;
        end
`endif
      end

      SHUTDOWN: begin
        dom_rst_n_d[idx_q] = 1'b0;
        if (idx_q == '0) begin
          state_d = SWHOLD;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      SWHOLD: begin
        dom_rst_n_d = '0;
        if (!sw_rst_p0) begin
          state_d = DLY;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      FAULT: begin
        dom_rst_n_d = '0;
        if (sw_evt) begin
          state_d   = SWHOLD;
          tmo_err_d = 1'b0;
          tmo_idx_d = '0;
        end
      end

      default: begin
        state_d     = HOLD;
        dom_rst_n_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= HOLD;
      idx_q       <= '0;
      cnt_q       <= '0;
      dom_rst_n_q <= '0;
      tmo_err_q   <= 1'b0;
      tmo_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dom_rst_n_q <= dom_rst_n_d;
      tmo_err_q   <= tmo_err_d;
      tmo_idx_q   <= tmo_idx_d;
    end
  end

  assign sif.o_dom_rst_n = dom_rst_n_q;
  assign sif.o_all_ready = (state_q == RUN);
  assign sif.o_busy      = (state_q == DLY) || (state_q == WAIT_RDY) || (state_q == SHUTDOWN);
  assign sif.o_tmo_err   = tmo_err_q;
  assign sif.o_tmo_idx   = tmo_idx_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomised bench for rst_sequencer: each episode derives the expected
// per-edge outputs from release/ready/abort timing arithmetic.
module tb_rst_sequencer;

  localparam int N_DOM       = 4;
  localparam int SYNC_STAGES = 3;
  localparam int REL_DLY     = 16;
  localparam int ACK_TMO     = 256;
  localparam int NEVER       = 1 << 20;

  logic i_clk    = 1'b0;
  logic i_arst_n = 1'b0;

  rst_seq_if #(.N_DOM(N_DOM)) sif ();

  rst_sequencer #(
    .N_DOM      (N_DOM),
    .SYNC_STAGES(SYNC_STAGES),
    .REL_DLY    (REL_DLY),
    .ACK_TMO    (ACK_TMO)
  ) dut (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .sif     (sif)
  );

  always #5 i_clk = ~i_clk;

  int edge_n = 0;
  always @(posedge i_clk) edge_n = edge_n + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int rdy_k  [N_DOM];
  int hi_cnt [N_DOM];
  logic [N_DOM-1:0] drop = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h, want %0h", tag, edge_n, obs, exp);
    end
  endtask

  // A domain reports ready once its reset has been high for rdy_k cycles.
  task automatic drive_ready();
    for (int d = 0; d < N_DOM; d++)
      sif.i_dom_ready[d] = (hi_cnt[d] >= rdy_k[d]) && !drop[d];
  endtask

  task automatic step();
    @(negedge i_clk);
    for (int d = 0; d < N_DOM; d++)
      hi_cnt[d] = sif.o_dom_rst_n[d] ? hi_cnt[d] + 1 : 0;
    drive_ready();
  endtask

  // mode 0: random abort point; 1: ready-drop test in RUN;
  // 2: 5-cycle sw pulse shortly after RUN; 3: abort while waiting on domain 1
  task automatic episode(input int start_t, input int d_entry, input int ks[N_DOM],
                         input int mode, output int next_d);
    int rel [N_DOM];
    int run_t, fault_t, fault_dom, t_dly, e, l, h, nd, nrel, fall, in_end;
    logic [N_DOM-1:0] exp_v;
    logic exp_busy, exp_all, exp_err;
    bit faulted;

    for (int d = 0; d < N_DOM; d++) begin
      rel[d]   = NEVER;
      rdy_k[d] = ks[d];
    end
    run_t = NEVER; fault_t = NEVER; fault_dom = 0; faulted = 0;
    t_dly = d_entry;
    for (int d = 0; d < N_DOM; d++) begin
      if (!faulted) begin
        rel[d] = t_dly + REL_DLY;
        if (ks[d] > ACK_TMO) begin
          fault_t   = rel[d] + ACK_TMO;
          fault_dom = d;
          faulted   = 1;
        end else begin
          t_dly = rel[d] + ks[d];
        end
      end
    end
    if (!faulted) run_t = t_dly;

    l = $urandom_range(1, 8);
    case (mode)
      1: begin
        e = run_t + 12;
`ifdef RST_SEQ_READY_MON_EN
        fault_t   = run_t + 8;
        fault_dom = N_DOM - 1;
`endif
      end
      2: begin e = run_t + $urandom_range(2, 6); l = 5; end
      3: e = rel[1] + 2;
      default: e = faulted ? fault_t + $urandom_range(1, 6)
                           : $urandom_range(d_entry + 1, run_t + 8);
    endcase

    nrel = 0;
    for (int d = 0; d < N_DOM; d++)
      if (rel[d] <= e && rel[d] < fault_t) nrel++;
    h  = (fault_t <= e) ? -1 : nrel - 1;
    nd = (e + 3 + h > e + l + 1) ? e + 3 + h : e + l + 1;

    for (int t = start_t; t < nd; t++) begin
      step();
      exp_v = '0;
      for (int d = 0; d < N_DOM; d++) begin
        fall = (fault_t <= e) ? fault_t : ((h >= 0) ? e + 2 + h - d : NEVER);
        if (rel[d] <= t && rel[d] <= e && rel[d] < fault_t && t < fall) exp_v[d] = 1'b1;
      end
      in_end = run_t;
      if (fault_t < in_end) in_end = fault_t;
      if (e + 1 < in_end) in_end = e + 1;
      exp_busy = (t >= d_entry && t < in_end) ||
                 (fault_t > e && h >= 0 && t >= e + 1 && t < e + 2 + h);
      exp_all  = (t >= run_t) && (t < fault_t) && (t < e + 1);
      exp_err  = (t >= fault_t) && (t < e + 1);
      chk("dom_rst_n", int'(sif.o_dom_rst_n), int'(exp_v));
      chk("busy",      int'(sif.o_busy),      int'(exp_busy));
      chk("all_ready", int'(sif.o_all_ready), int'(exp_all));
      chk("tmo_err",   int'(sif.o_tmo_err),   int'(exp_err));
      chk("tmo_idx",   int'(sif.o_tmo_idx),   exp_err ? fault_dom : 0);

      if (t == e - 1)     sif.i_sw_rst = 1'b1;
      if (t == e + l - 1) sif.i_sw_rst = 1'b0;
      if (mode == 1) begin
        if (t == run_t + 2 || t == run_t + 6) drop[N_DOM-1] = 1'b1;
        if (t == run_t + 3 || t == run_t + 8) drop[N_DOM-1] = 1'b0;
        drive_ready();
      end
    end
    next_d = nd;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ks [N_DOM];
    int nd, nd2, base;

    sif.i_sw_rst    = 1'b0;
    sif.i_dom_ready = '0;
    for (int d = 0; d < N_DOM; d++) begin
      rdy_k[d]  = 1;
      hi_cnt[d] = 0;
    end
    repeat (3) @(negedge i_clk);
    chk("rst_dom_rst_n", int'(sif.o_dom_rst_n), 0);
    chk("rst_busy",      int'(sif.o_busy),      0);
    chk("rst_all_ready", int'(sif.o_all_ready), 0);
    chk("rst_tmo_err",   int'(sif.o_tmo_err),   0);
    chk("rst_tmo_idx",   int'(sif.o_tmo_idx),   0);

    // Power-on with every domain ready immediately, then a 5-cycle sw pulse.
    base = edge_n;
    i_arst_n = 1'b1;
    for (int d = 0; d < N_DOM; d++) ks[d] = 1;
    episode(base + 1, base + 1 + SYNC_STAGES, ks, 2, nd);

    // Domain 2 never readies: timeout, then sw recovery.
    for (int d = 0; d < N_DOM; d++) ks[d] = $urandom_range(1, 8);
    ks[2] = NEVER;
    episode(nd, nd, ks, 0, nd2);

    // Ready arriving exactly on the timeout cycle is a success.
    for (int d = 0; d < N_DOM; d++) ks[d] = $urandom_range(1, 5);
    ks[1] = ACK_TMO;
    episode(nd2, nd2, ks, 2, nd);

    // Abort while waiting on domain 1.
    for (int d = 0; d < N_DOM; d++) ks[d] = $urandom_range(1, 5);
    ks[1] = 10;
    episode(nd, nd, ks, 3, nd2);
    nd = nd2;

    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < N_DOM; d++) begin
        ks[d] = $urandom_range(1, 30);
        if ($urandom_range(0, 11) == 0) ks[d] = ACK_TMO + 1;
      end
      episode(nd, nd, ks, 0, nd2);
      nd = nd2;
    end

    // Ready drops in RUN: one-cycle drop, then a two-cycle drop.
    for (int d = 0; d < N_DOM; d++) ks[d] = $urandom_range(1, 6);
    episode(nd, nd, ks, 1, nd2);
    nd = nd2;

    // Asynchronous board reset in the middle of a release delay.
    for (int d = 0; d < N_DOM; d++) rdy_k[d] = 1;
    while (edge_n < nd + REL_DLY + 5) step();
    chk("pre_arst_bit0", int'(sif.o_dom_rst_n[0]), 1);
    #2 i_arst_n = 1'b0;
    #1;
    chk("arst_dom_rst_n", int'(sif.o_dom_rst_n), 0);
    chk("arst_busy",      int'(sif.o_busy),      0);
    chk("arst_all_ready", int'(sif.o_all_ready), 0);
    chk("arst_tmo_err",   int'(sif.o_tmo_err),   0);
    @(negedge i_clk);
    chk("arst_hold_dom_rst_n", int'(sif.o_dom_rst_n), 0);
    for (int d = 0; d < N_DOM; d++) hi_cnt[d] = 0;
    drive_ready();
    base = edge_n;
    i_arst_n = 1'b1;
    for (int d = 0; d < N_DOM; d++) ks[d] = 1;
    episode(base + 1, base + 1 + SYNC_STAGES, ks, 2, nd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
